// File: rtl/adsr_pkg.sv
// -----------------------------------------------------------------------------
// adsr_pkg
// Shared definitions for the ADSR envelope block: default sample/level widths,
// the full-scale level constant and the envelope state encoding.
// Optional feature macro used by adsr_envelope: ADSR_EXP_RELEASE_EN
// (exponential-like release tail instead of linear release).
// -----------------------------------------------------------------------------
package adsr_pkg;

    localparam int DEFAULT_SAMPLE_W = 16;
    localparam int DEFAULT_LEVEL_W  = 16;

    // Full-scale envelope level for the default level width (2^LEVEL_W - 1)
    localparam logic [DEFAULT_LEVEL_W-1:0] LEVEL_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_scaler.sv
// -----------------------------------------------------------------------------
// adsr_scaler
// Two-stage pipeline applying the envelope level to an audio sample:
//   stage 1 : registered signed(sample) x unsigned(level) product
//   stage 2 : registered arithmetic shift right by LEVEL_W (floor)
// A matching two-flop valid shift register marks the output strobe.
// Ports:
//   clock, reset       - system clock, asynchronous active-high reset
//   sample_in          - signed input sample (SAMPLE_W)
//   sample_in_valid    - input strobe
//   level              - unsigned envelope level (LEVEL_W)
//   sample_out         - signed scaled sample (SAMPLE_W)
//   sample_out_valid   - output strobe, two cycles after sample_in_valid
// -----------------------------------------------------------------------------
module adsr_scaler
    import adsr_pkg::*;
#(
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int LEVEL_W  = DEFAULT_LEVEL_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_in_valid,
    input  logic [LEVEL_W-1:0]  level,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_out_valid
);

    // Level is zero-extended by one bit so it multiplies as a positive value
    localparam int PROD_W = SAMPLE_W + LEVEL_W + 1;

    logic signed [PROD_W-1:0]   sample_ext;
    logic signed [PROD_W-1:0]   level_ext;
    logic signed [PROD_W-1:0]   product_next;
    logic signed [PROD_W-1:0]   product_reg;
    logic                       product_valid_reg;
    logic [SAMPLE_W-1:0]        sample_out_reg;
    logic                       sample_out_valid_reg;

    assign sample_ext   = {{(LEVEL_W + 1){sample_in[SAMPLE_W-1]}}, sample_in};
    assign level_ext    = {{(SAMPLE_W + 1){1'b0}}, level};
    assign product_next = sample_ext * level_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            product_reg          <= '0;
            product_valid_reg    <= 1'b0;
            sample_out_reg       <= '0;
            sample_out_valid_reg <= 1'b0;
        end else begin
            product_valid_reg    <= sample_in_valid;
            sample_out_valid_reg <= product_valid_reg;
            if (sample_in_valid) begin
                product_reg <= product_next;
            end
            if (product_valid_reg) begin
                // Arithmetic shift floors toward -inf; result always fits SAMPLE_W
                sample_out_reg <= SAMPLE_W'(product_reg >>> LEVEL_W);
            end
        end
    end

    assign sample_out       = sample_out_reg;
    assign sample_out_valid = sample_out_valid_reg;

endmodule

// File: rtl/adsr_envelope.sv
// -----------------------------------------------------------------------------
// adsr_envelope
// Per-voice ADSR amplitude envelope. The key gate is synchronised and edge
// detected; a rising edge sets a sticky retrigger flag consumed by the next
// sample strobe. The envelope FSM advances only on sample_in_valid, and the
// sample is scaled by the level held before that strobe's update.
// Optional feature macro: ADSR_EXP_RELEASE_EN -- when defined, the release
// step is (level >> release_rate[3:0]) + 1 instead of release_rate.
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   gate                - key held (asynchronous to clock)
//   attack_rate         - level added per strobe in ATTACK (0 = jump to max)
//   decay_rate          - level removed per strobe in DECAY (0 = jump to sustain)
//   sustain_level       - hold level, tracked live in SUSTAIN
//   release_rate        - level removed per strobe in RELEASE (0 = jump to 0)
//   sample_in/_valid    - signed oscillator sample and its strobe
//   sample_out/_valid   - enveloped sample, strobe two cycles after input
//   env_level           - current envelope level
//   env_state           - current state (IDLE=0 .. RELEASE=4)
// -----------------------------------------------------------------------------
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int LEVEL_W  = DEFAULT_LEVEL_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                gate,
    input  logic [LEVEL_W-1:0]  attack_rate,
    input  logic [LEVEL_W-1:0]  decay_rate,
    input  logic [LEVEL_W-1:0]  sustain_level,
    input  logic [LEVEL_W-1:0]  release_rate,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_in_valid,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_out_valid,
    output logic [LEVEL_W-1:0]  env_level,
    output logic [2:0]          env_state
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

    logic           gate_meta_reg;
    logic           gate_sync_reg;
    logic           gate_prev_reg;
    logic           gate_rise;
    logic           retrig_reg;

    adsr_state_t        state_reg;
    adsr_state_t        state_next;
    adsr_state_t        target_state;
    logic [LEVEL_W-1:0] level_reg;
    logic [LEVEL_W-1:0] level_next;

    // One extra bit so overflow/underflow is visible before saturation
    logic [LEVEL_W:0]   attack_sum;
    logic [LEVEL_W:0]   decay_diff;
    logic [LEVEL_W:0]   release_step;
    logic [LEVEL_W:0]   release_diff;
    logic               release_jump;

    assign gate_rise = gate_sync_reg & ~gate_prev_reg;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gate_meta_reg <= 1'b0;
            gate_sync_reg <= 1'b0;
            gate_prev_reg <= 1'b0;
            retrig_reg    <= 1'b0;
            state_reg     <= ST_IDLE;
            level_reg     <= '0;
        end else begin
            gate_meta_reg <= gate;
            gate_sync_reg <= gate_meta_reg;
            gate_prev_reg <= gate_sync_reg;
            // A rise coinciding with a strobe wins, so it is served by the
            // following strobe rather than being dropped.
            if (gate_rise) begin
                retrig_reg <= 1'b1;
            end else if (sample_in_valid) begin
                retrig_reg <= 1'b0;
            end
            if (sample_in_valid) begin
                state_reg <= state_next;
                level_reg <= level_next;
            end
        end
    end

    // ---------------------------------------------------------- level arithmetic
    assign attack_sum = {1'b0, level_reg} + {1'b0, attack_rate};
    assign decay_diff = {1'b0, level_reg} - {1'b0, decay_rate};

`ifdef ADSR_EXP_RELEASE_EN
    assign release_step = {1'b0, (level_reg >> release_rate[3:0])} + {{LEVEL_W{1'b0}}, 1'b1};
    assign release_jump = 1'b0;
`else
    assign release_step = {1'b0, release_rate};
    assign release_jump = (release_rate == '0);
`endif

    assign release_diff = {1'b0, level_reg} - release_step;

    // ------------------------------------------------------ next state / level
    // The strobe first picks the state it acts in (retrigger beats gate
    // release), then applies that state's level step, moving on when the
    // step's end point is reached.
    always_comb begin
        target_state = state_reg;
        if (retrig_reg) begin
            target_state = ST_ATTACK;
        end else if (!gate_sync_reg &&
                     (state_reg == ST_ATTACK || state_reg == ST_DECAY ||
                      state_reg == ST_SUSTAIN)) begin
            target_state = ST_RELEASE;
        end

        state_next = target_state;
        level_next = level_reg;

        case (target_state)
            ST_ATTACK: begin
                if (attack_rate == '0 || attack_sum[LEVEL_W] ||
                    attack_sum[LEVEL_W-1:0] == LVL_MAX) begin
                    level_next = LVL_MAX;
                    state_next = ST_DECAY;
                end else begin
                    level_next = attack_sum[LEVEL_W-1:0];
                end
            end
            ST_DECAY: begin
                if (decay_rate == '0 || decay_diff[LEVEL_W] ||
                    decay_diff[LEVEL_W-1:0] <= sustain_level) begin
                    level_next = sustain_level;
                    state_next = ST_SUSTAIN;
                end else begin
                    level_next = decay_diff[LEVEL_W-1:0];
                end
            end
            ST_SUSTAIN: begin
                level_next = sustain_level;
            end
            ST_RELEASE: begin
                if (release_jump || release_diff[LEVEL_W] ||
                    release_diff[LEVEL_W-1:0] == '0) begin
                    level_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    level_next = release_diff[LEVEL_W-1:0];
                end
            end
            default: begin
                level_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ sample scaler
    adsr_scaler #(
        .SAMPLE_W (SAMPLE_W),
        .LEVEL_W  (LEVEL_W)
    ) u_scaler (
        .clock            (clock),
        .reset            (reset),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .level            (level_reg),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid)
    );

    assign env_level = level_reg;
    assign env_state = state_reg;

endmodule
